// File: rtl/mux4_rr_arbiter_if.sv
// Bus bundle for mux4_rr_arbiter.
//   req      : per-source request (source -> arbiter)
//   in0..in3 : per-source data words (source -> arbiter)
//   gnt      : one-hot accept strobe (arbiter -> source)
//   sel      : index of the source held in the output register
//   out_data : registered data of the granted source
//   out_valid: out_data holds an unconsumed word
//   out_ready: consumer accepts out_data when out_valid && out_ready
// Modports: master = arbiter side, slave = requesters/consumer side.
interface mux4_rr_arbiter_if #(
  parameter int DW = 4
);
  logic [3:0]    req;
  logic [DW-1:0] in0;
  logic [DW-1:0] in1;
  logic [DW-1:0] in2;
  logic [DW-1:0] in3;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    input  req, in0, in1, in2, in3, out_ready,
    output gnt, sel, out_data, out_valid
  );

  modport slave (
    output req, in0, in1, in2, in3, out_ready,
    input  gnt, sel, out_data, out_valid
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 select datapath among four requesters.
// Each cycle at most one requesting source is accepted (gnt), its word is
// registered into a single valid/ready output stage, and sel records which
// source the held word came from.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   bus : mux4_rr_arbiter_if.master (req, in0..in3, gnt, sel, out_data,
//         out_valid, out_ready)
module mux4_rr_arbiter #(
  parameter int DW = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux4_rr_arbiter_if.master bus
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    sel_q;
  logic [DW-1:0] data_q;

  logic          load;
  logic          found;
  logic [1:0]    win;
  logic [DW-1:0] win_data;

  // Output register is free, or is being emptied this cycle.
  always_comb begin
    load = (state == IDLE) || bus.out_ready;
  end

  // Rotating priority search starting at ptr.
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    case (win)
      2'd0:    win_data = bus.in0;
      2'd1:    win_data = bus.in1;
      2'd2:    win_data = bus.in2;
      default: win_data = bus.in3;
    endcase
  end

  // Accept strobe is suppressed during reset so no word is taken then.
  always_comb begin
    bus.gnt = '0;
    if (!rst && load && found) begin
      bus.gnt[win] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      sel_q  <= '0;
      data_q <= '0;
    end else if (load) begin
      if (found) begin
        state  <= FULL;
        data_q <= win_data;
        sel_q  <= win;
        ptr    <= win + 2'd1;
      end else begin
        state  <= IDLE;
      end
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer that shares one 4:1 select datapath among four requesters. Each cycle it chooses at most one requesting source, drives the 2-bit mux select, and registers the chosen source's data into a single valid/ready output stage. It sits in front of any shared single-consumer resource in the core, such as a writeback or bus port.

## Interface
- DW, 4, width of each source data word and of out_data
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req  in  4  request per source; bit i means in_i holds valid data
- in0, in1, in2, in3  in  DW each  source data words
- gnt  out  4  one-hot accept strobe; gnt[i]=1 means in_i is captured at this clock edge
- sel  out  2  index of the source currently held in the output register; drives the mux select
- out_data  out  DW  registered data of the granted source
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready

## Operation
- State machine with two states:
  - IDLE (out_valid=0)
  - FULL (out_valid=1)
- load = (state==IDLE) || (out_valid && out_ready). This is the output register's free-or-freeing condition.
- Arbitration is evaluated only when load=1 and req!=0:
  - Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - The first requesting index is the winner w.
- On load with a winner:
  - gnt[w]=1 combinationally in the same cycle.
  - At the clock edge: out_data<=in_w, sel<=w, out_valid<=1, ptr<=w+1 mod 4 (3 wraps to 0).
- On load with no winner:
  - gnt=0.
  - At the clock edge: out_valid<=0 and state goes to IDLE.
  - sel, out_data and ptr hold their values.
- In FULL with out_ready=0:
  - gnt=0.
  - out_data, sel, out_valid and ptr all hold.
  - req is ignored.
- gnt is one-hot or zero, never multi-hot. gnt[i] is never asserted when req[i]=0.
- Requesters must deassert or refresh req[i] on the cycle after gnt[i]. A held req[i] is treated as a new word.
- Fairness: a requester that holds req is granted within 4 loads.

## Timing
- Reset values: out_valid=0, out_data=0, sel=0, ptr=0, state=IDLE.
  - gnt=0 in every cycle where rst=1.
  - req is ignored during reset.
- Latency: data presented with gnt in cycle N appears on out_data with out_valid=1 in cycle N+1.
- Throughput: one word per cycle when out_ready stays high and req is nonzero (back-to-back handshake plus reload in the same cycle).
- Output stability: while out_valid=1 and out_ready=0, out_data and sel must not change.
- Simultaneous consume and reload: the old word is accepted and the new word is loaded at the same edge; out_valid stays 1.
- Reset mid-transfer: an unconsumed word is dropped and out_valid=0 on the next cycle. There is no gnt in the reset cycle.
- out_ready while out_valid=0 has no effect.

## Test plan
- Reset, then req=4'b0000 for 5 cycles -> out_valid=0, gnt=0, sel=0 throughout.
- req=4'b1111 held, out_ready=1, in0..in3=A,B,C,D -> gnt sequence 0001, 0010, 0100, 1000, 0001; out_data A,B,C,D,A starting one cycle after the first gnt; sel 0,1,2,3,0.
- Single grant of in2=5 followed by out_ready=0 for 3 cycles while req=4'b0011:
  - During the stall: out_data=5, sel=2, gnt=0.
  - First cycle out_ready=1: gnt=4'b1000? No, req=4'b0011 and ptr=3, so the search wraps and gnt=4'b0001.
- Pointer wrap: after a grant to source 3 (ptr=0), req=4'b1001 -> gnt=4'b0001.
- Consume and reload in the same cycle: out_valid=1, out_ready=1, req=4'b0100 -> out_valid stays 1 and out_data updates to in2 at the next edge with no bubble. After that, req=0 and out_ready=1 -> out_valid=0 next cycle.
- Assert rst while out_valid=1 and req=4'b1111 -> next cycle out_valid=0, sel=0, gnt=0. After release, the first grant goes to source 0.
